// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the data-memory port between two requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; default is port 0 priority.
module data_mem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    input  logic [3:0]        bsel0,
    input  logic [3:0]        bsel1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_bsel,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        RESP
    } state_t;

    state_t state, state_n;
    logic owner, owner_n;
    logic [7:0] cnt;
    logic grant, pick1, rd_done, rd_tmo;

    logic ack0_n, ack1_n, err0_n, err1_n;
    logic ren_n, wen_n;
    logic [31:0] rdata_n, wdata_n;
    logic [ADDR_W-1:0] addr_n;
    logic [3:0] bsel_n;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner;

    assign pick1 = req1 && (!req0 || !last_owner);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= 1'b1;
        end else if (grant) begin
            last_owner <= pick1;
        end
    end
`else
    assign pick1 = req1 && !req0;
`endif

    // A busy memory (e.g. after a reset mid-read) must not be issued to
    assign grant = (state == IDLE) && (req0 || req1) && mem_ready;

    // mem_ready is ignored in the first wait cycle (cnt == 0)
    assign rd_done = (state == RD_WAIT) && (cnt != 8'd0) && mem_ready;
    assign rd_tmo  = (state == RD_WAIT) && !rd_done &&
                     (cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= 1'b0;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            cnt   <= (state == RD_WAIT) ? cnt + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    owner_n = pick1;
                    state_n = (pick1 ? we1 : we0) ? WR_ISSUE : RD_ISSUE;
                end
            end
            WR_ISSUE: state_n = RESP;
            RD_ISSUE: state_n = RD_WAIT;
            RD_WAIT: begin
                if (rd_done || rd_tmo) begin
                    state_n = RESP;
                end
            end
            RESP:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        err0_n  = 1'b0;
        err1_n  = 1'b0;
        ren_n   = 1'b0;
        wen_n   = 1'b0;
        rdata_n = 32'd0;
        wdata_n = 32'd0;
        bsel_n  = 4'd0;
        addr_n  = '0;
        unique case (state_n)
            WR_ISSUE: begin
                wen_n   = 1'b1;
                addr_n  = pick1 ? addr1 : addr0;
                wdata_n = pick1 ? wdata1 : wdata0;
                bsel_n  = pick1 ? bsel1 : bsel0;
            end
            RD_ISSUE: begin
                ren_n  = 1'b1;
                addr_n = pick1 ? addr1 : addr0;
            end
            RD_WAIT: addr_n = mem_addr;
            RESP: begin
                ack0_n  = !owner_n;
                ack1_n  = owner_n;
                err0_n  = rd_tmo && !owner_n;
                err1_n  = rd_tmo && owner_n;
                rdata_n = rd_done ? mem_rdata : 32'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata     <= 32'd0;
            mem_addr  <= '0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_wdata <= 32'd0;
            mem_bsel  <= 4'd0;
        end else begin
            ack0      <= ack0_n;
            ack1      <= ack1_n;
            err0      <= err0_n;
            err1      <= err1_n;
            rdata     <= rdata_n;
            mem_addr  <= addr_n;
            mem_ren   <= ren_n;
            mem_wen   <= wen_n;
            mem_wdata <= wdata_n;
            mem_bsel  <= bsel_n;
        end
    end

endmodule
